y86_seq_sequencer: RTL
======================

# y86_seq_sequencer

Multi-cycle stage sequencer for the sequential Y86-64 core. Owns the architectural PC, steps the fetch, decode, execute, memory, writeback and PC-update stages one per cycle via one-hot enables, selects the next PC, and converts fetch and data-memory faults into the Y86 status code. Sits above the stage modules and is the only block that writes PC.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- run  in  1  level: execute instructions continuously
- step  in  1  pulse: execute exactly one instruction from IDLE
- icode  in  4  from fetch
- hlt, inst_valid, mem_error  in  1 each  fetch status
- valC, valP  in  64 each  from fetch
- valM  in  64  from memory stage
- cnd  in  1  branch condition from execute
- dmem_error  in  1  data-memory address fault
- PC  out  64  current instruction address
- f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  one-hot stage enables
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  high in any state except IDLE and HALTED
- cycle_count  out  32  cycles spent outside IDLE/HALTED
- instr_count  out  32  instructions retired

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. Registered state, encoding free.
- Enables are decoded from state: FETCH→f_en, DECODE→d_en, EXECUTE→e_en, MEMORY→m_en, PCUPD→pc_en; at most one high. w_en = (state==WRITEBACK) & ~dmem_error.
- IDLE: run or step → FETCH; else stay. run and step together behave as run. step outside IDLE is ignored.
- FETCH → DECODE unconditionally.
- DECODE: fetch outputs are registered, valid this cycle. Fault check, priority mem_error > ~inst_valid > hlt: mem_error → stat=ADR, ~inst_valid → stat=INS, hlt (icode 0) → stat=HLT; any of these → HALTED. Else → EXECUTE.
- EXECUTE → MEMORY; MEMORY → WRITEBACK.
- WRITEBACK: dmem_error → stat=ADR, w_en suppressed, → HALTED. Else → PCUPD.
- PCUPD: next PC = valC if icode==8 (call) or (icode==7 and cnd); valM if icode==9 (ret); else valP. PC loads it, instr_count +1, then → FETCH if run, else IDLE.
- HALTED: absorbing; PC, stat, counters frozen; all enables 0; only reset leaves it.
- On a fault PC keeps the address of the faulting instruction; instr_count does not count it.
- Counters wrap modulo 2^32 silently.
- run deasserted mid-instruction does not abort; current instruction completes through PCUPD, then IDLE.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, stat=1 (AOK), all enables 0, busy 0, cycle_count 0, instr_count 0.
- Reset asserted in any state wins over every other input in that cycle; next cycle shows reset values.
- Latency: 6 cycles per instruction, FETCH to PCUPD inclusive. With run held, new PC visible the cycle FETCH re-enters; back-to-back throughput 1 instruction / 6 cycles.
- From IDLE, the edge sampling run/step enters FETCH; f_en high the following cycle.
- Fault detection: fetch faults resolve at the DECODE→HALTED edge (2 cycles after FETCH entry); dmem_error at WRITEBACK.
- stat and PC change only on the edges named above; stat never returns to AOK without reset.
- cycle_count increments on every edge where state ∉ {IDLE, HALTED}, including the edge leaving into HALTED.

## Test plan
- Reset, run=1, fetch returns icode 1 (nop), valP=PC+1 → enables cycle f,d,e,m,w,pc; PC 0→1→2 every 6 cycles; instr_count=2 after 12 cycles.
- icode 7, cnd=1, valC=0x40 → PC=0x40 at PCUPD; repeat with cnd=0, valP=0x49 → PC=0x49.
- icode 8 valC=0x100, then icode 9 valM=0x2A → PC 0x100 then 0x2A.
- hlt=1 at DECODE → stat=2, HALTED, busy=0, PC unchanged; inst_valid=0 with mem_error=1 same cycle → stat=3.
- dmem_error=1 during WRITEBACK → w_en=0, stat=3, HALTED; later reset → PC=RESET_PC, stat=1, counters 0.
- run=0, single step pulse → exactly one instruction, instr_count=1, back to IDLE; reset asserted in EXECUTE → IDLE next cycle, all enables 0.

Source files
------------

// File: rtl/y86_seq_sequencer_if.sv
// Bus between the Y86-64 stage sequencer and the stage datapath / debug control.
// master: the sequencer itself. slave: the stage modules and run/step controller.
interface y86_seq_sequencer_if;
    // control
    logic        run;
    logic        step;
    // fetch stage results
    logic [3:0]  icode;
    logic        hlt;
    logic        inst_valid;
    logic        mem_error;
    logic [63:0] valC;
    logic [63:0] valP;
    // execute / memory stage results
    logic [63:0] valM;
    logic        cnd;
    logic        dmem_error;
    // sequencer outputs
    logic [63:0] PC;
    logic        f_en;
    logic        d_en;
    logic        e_en;
    logic        m_en;
    logic        w_en;
    logic        pc_en;
    logic [2:0]  stat;
    logic        busy;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    modport master (
        input  run, step, icode, hlt, inst_valid, mem_error, valC, valP, valM, cnd, dmem_error,
        output PC, f_en, d_en, e_en, m_en, w_en, pc_en, stat, busy, cycle_count, instr_count
    );

    modport slave (
        output run, step, icode, hlt, inst_valid, mem_error, valC, valP, valM, cnd, dmem_error,
        input  PC, f_en, d_en, e_en, m_en, w_en, pc_en, stat, busy, cycle_count, instr_count
    );
endinterface

// File: rtl/y86_seq_sequencer.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core.
// Owns PC, steps one stage per cycle, picks the next PC and folds faults into stat.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for run or a step pulse
// FETCH     | fetch stage enabled
// DECODE    | decode enabled; fetch faults checked here
// EXECUTE   | execute enabled
// MEMORY    | data memory access enabled
// WRITEBACK | register write (suppressed on data-memory fault)
// PCUPD     | PC loads next address, instruction retires
// HALTED    | absorbing after HLT/ADR/INS; only reset leaves
module y86_seq_sequencer #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input logic            clk,
    input logic            reset,
    y86_seq_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IC_JXX  = 4'd7;
    localparam logic [3:0] IC_CALL = 4'd8;
    localparam logic [3:0] IC_RET  = 4'd9;

    state_t      state;
    logic [63:0] pc_q;
    logic [2:0]  stat_q;
    logic [31:0] cycle_q;
    logic [31:0] instr_q;
    logic [63:0] next_pc;
    logic        active;

    assign active = (state != S_IDLE) && (state != S_HALTED);

    // Next-PC select: call and taken jump go to valC, ret to valM, else fall through.
    always_comb begin
        next_pc = bus.valP;
        if (bus.icode == IC_CALL || (bus.icode == IC_JXX && bus.cnd))
            next_pc = bus.valC;
        else if (bus.icode == IC_RET)
            next_pc = bus.valM;
    end

    // Stage FSM with PC, status and counters; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            if (active)
                cycle_q <= cycle_q + 32'd1;
            case (state)
                S_IDLE: begin
                    if (bus.run || bus.step)
                        state <= S_FETCH;
                end
                S_FETCH:   state <= S_DECODE;
                S_DECODE: begin
                    if (bus.mem_error) begin
                        stat_q <= STAT_ADR;
                        state  <= S_HALTED;
                    end else if (!bus.inst_valid) begin
                        stat_q <= STAT_INS;
                        state  <= S_HALTED;
                    end else if (bus.hlt) begin
                        stat_q <= STAT_HLT;
                        state  <= S_HALTED;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: state <= S_MEMORY;
                S_MEMORY:  state <= S_WRITEBACK;
                S_WRITEBACK: begin
                    if (bus.dmem_error) begin
                        stat_q <= STAT_ADR;
                        state  <= S_HALTED;
                    end else begin
                        state <= S_PCUPD;
                    end
                end
                S_PCUPD: begin
                    pc_q    <= next_pc;
                    instr_q <= instr_q + 32'd1;
                    state   <= bus.run ? S_FETCH : S_IDLE;
                end
                S_HALTED:  state <= S_HALTED;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Stage enables decode straight from the state register; w_en also gated by the live fault.
    assign bus.f_en  = (state == S_FETCH);
    assign bus.d_en  = (state == S_DECODE);
    assign bus.e_en  = (state == S_EXECUTE);
    assign bus.m_en  = (state == S_MEMORY);
    assign bus.w_en  = (state == S_WRITEBACK) && !bus.dmem_error;
    assign bus.pc_en = (state == S_PCUPD);

    assign bus.PC          = pc_q;
    assign bus.stat        = stat_q;
    assign bus.busy        = active;
    assign bus.cycle_count = cycle_q;
    assign bus.instr_count = instr_q;

endmodule
